// File: rtl/accel_wr_dma_sp_if.sv
// Signal bundle for the single-port write DMA: descriptor, stop, input stream,
// SRAM write port and completion status.
interface accel_wr_dma_sp_if #(
  parameter int DATA_WIDTH      = 128,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH      = 16,
  parameter int LINE_ADDR_WIDTH = ADDR_WIDTH - $clog2(KEEP_WIDTH),
  parameter int LEN_WIDTH       = 14
);
  logic [ADDR_WIDTH-1:0]      desc_addr;
  logic [LEN_WIDTH-1:0]       desc_len;
  logic                       desc_valid;
  logic                       desc_ready;
  logic                       stop;
  logic [DATA_WIDTH-1:0]      s_axis_tdata;
  logic [KEEP_WIDTH-1:0]      s_axis_tkeep;
  logic                       s_axis_tlast;
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic                       mem_wr_en;
  logic [KEEP_WIDTH-1:0]      mem_wr_strb;
  logic [LINE_ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0]      mem_wr_data;
  logic                       done_valid;
  logic [LEN_WIDTH-1:0]       done_len;
  logic                       done_overflow;
  logic                       done_aborted;

  modport slave (
    input  desc_addr, desc_len, desc_valid, stop,
           s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    output desc_ready, s_axis_tready, mem_wr_en, mem_wr_strb, mem_wr_addr,
           mem_wr_data, done_valid, done_len, done_overflow, done_aborted
  );

  modport master (
    output desc_addr, desc_len, desc_valid, stop,
           s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    input  desc_ready, s_axis_tready, mem_wr_en, mem_wr_strb, mem_wr_addr,
           mem_wr_data, done_valid, done_len, done_overflow, done_aborted
  );
endinterface

// File: rtl/accel_wr_dma_sp.sv
// Write DMA: realigns an AXI-Stream packet to an arbitrary byte address and
// writes it line by line into one SRAM port, with a length cap and abort.
module accel_wr_dma_sp #(
  parameter int DATA_WIDTH      = 128,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH      = 16,
  parameter int LINE_ADDR_WIDTH = ADDR_WIDTH - $clog2(KEEP_WIDTH),
  parameter int LEN_WIDTH       = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  accel_wr_dma_sp_if.slave bus
);
  localparam int OW = $clog2(KEEP_WIDTH);
  localparam int CW = OW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic                       r_live;
  logic [LINE_ADDR_WIDTH-1:0] r_line;
  logic [OW-1:0]              r_off;
  logic [LEN_WIDTH-1:0]       r_len, r_cnt, r_wlen;
  logic                       r_ovf;
  logic [DATA_WIDTH-1:0]      r_res_data;
  logic [KEEP_WIDTH-1:0]      r_res_strb;
  logic                       r_wr_en;
  logic [KEEP_WIDTH-1:0]      r_wr_strb;
  logic [LINE_ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0]      r_wr_data;
  logic [LEN_WIDTH-1:0]       r_done_len;
  logic                       r_done_ovf, r_done_abt;

  logic                    w_desc_rdy, w_tready, w_done_vld, w_beat, w_flush_wr;
  logic                    w_run, w_full, w_beat_ovf;
  logic [CW-1:0]           w_ones, w_nb, w_end;
  logic [LEN_WIDTH-1:0]    w_room, w_take;
  logic [KEEP_WIDTH-1:0]   w_bstrb, w_lo_strb, w_hi_strb;
  logic [2*DATA_WIDTH-1:0] w_sh_data;
  logic [2*KEEP_WIDTH-1:0] w_sh_strb;
  logic [DATA_WIDTH-1:0]   w_lo_data;

  function automatic logic [LEN_WIDTH-1:0] popcnt(input logic [KEEP_WIDTH-1:0] s);
    logic [LEN_WIDTH-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) n = n + LEN_WIDTH'(s[i]);
    return n;
  endfunction

  // Beat realignment: low half completes the current line, high half is carry.
  always_comb begin
    w_ones = '0;
    w_run  = 1'b1;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      if (w_run && bus.s_axis_tkeep[i]) w_ones = w_ones + CW'(1);
      else                               w_run  = 1'b0;
    end
    w_nb       = bus.s_axis_tlast ? w_ones : CW'(KEEP_WIDTH);
    w_room     = r_len - r_cnt;
    w_beat_ovf = LEN_WIDTH'(w_nb) > w_room;
    w_take     = w_beat_ovf ? w_room : LEN_WIDTH'(w_nb);
    for (int unsigned k = 0; k < KEEP_WIDTH; k++)
      w_bstrb[k] = (CW'(k) < w_nb) && (LEN_WIDTH'(k) < w_room);
    w_sh_data = {{DATA_WIDTH{1'b0}}, bus.s_axis_tdata} << {r_off, 3'b000};
    w_sh_strb = {{KEEP_WIDTH{1'b0}}, w_bstrb} << r_off;
    w_lo_data = w_sh_data[DATA_WIDTH-1:0] | r_res_data;
    w_lo_strb = w_sh_strb[KEEP_WIDTH-1:0] | r_res_strb;
    w_hi_strb = w_sh_strb[2*KEEP_WIDTH-1:KEEP_WIDTH];
    w_end     = CW'(r_off) + w_nb;
    w_full    = !bus.s_axis_tlast || (w_end >= CW'(KEEP_WIDTH));
  end

  // After tlast the FSM always passes through FLUSH so that done_valid lands
  // one cycle after the last registered write, flush or not.
  always_comb begin
    w_state_nxt = r_state;
    w_desc_rdy  = 1'b0;
    w_tready    = 1'b0;
    w_done_vld  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_desc_rdy = r_live;
        if (r_live && bus.desc_valid) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (bus.stop) begin
          w_state_nxt = S_DONE;
        end else begin
          w_tready = 1'b1;
          if (bus.s_axis_tvalid && bus.s_axis_tlast) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (bus.stop || r_res_strb == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done_vld  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_beat     = w_tready && bus.s_axis_tvalid;
  assign w_flush_wr = (r_state == S_FLUSH) && !bus.stop && (r_res_strb != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live     <= 1'b0;
      r_line     <= '0;
      r_off      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_wlen     <= '0;
      r_ovf      <= 1'b0;
      r_res_data <= '0;
      r_res_strb <= '0;
      r_wr_en    <= 1'b0;
      r_wr_strb  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_done_len <= '0;
      r_done_ovf <= 1'b0;
      r_done_abt <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_wr_en <= 1'b0;
      if (w_desc_rdy && bus.desc_valid) begin
        r_line     <= bus.desc_addr[ADDR_WIDTH-1:OW];
        r_off      <= bus.desc_addr[OW-1:0];
        r_len      <= bus.desc_len;
        r_cnt      <= '0;
        r_wlen     <= '0;
        r_ovf      <= 1'b0;
        r_res_data <= '0;
        r_res_strb <= '0;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + w_take;
        if (w_beat_ovf) r_ovf <= 1'b1;
        if (w_full) begin
          r_line     <= r_line + LINE_ADDR_WIDTH'(1);
          r_res_data <= w_sh_data[2*DATA_WIDTH-1:DATA_WIDTH];
          r_res_strb <= w_hi_strb;
          if (w_lo_strb != '0) begin
            r_wr_en   <= 1'b1;
            r_wr_strb <= w_lo_strb;
            r_wr_addr <= r_line;
            r_wr_data <= w_lo_data;
            r_wlen    <= r_wlen + popcnt(w_lo_strb);
          end
        end else begin
          // Partial final line is held back and written from FLUSH.
          r_res_data <= w_lo_data;
          r_res_strb <= w_lo_strb;
        end
      end
      if (w_flush_wr) begin
        r_wr_en    <= 1'b1;
        r_wr_strb  <= r_res_strb;
        r_wr_addr  <= r_line;
        r_wr_data  <= r_res_data;
        r_wlen     <= r_wlen + popcnt(r_res_strb);
        r_res_strb <= '0;
      end
      if (w_state_nxt == S_DONE && r_state != S_DONE) begin
        r_done_len <= r_wlen;
        r_done_ovf <= r_ovf;
        r_done_abt <= bus.stop;
      end
    end
  end

  assign bus.desc_ready    = w_desc_rdy;
  assign bus.s_axis_tready = w_tready;
  assign bus.mem_wr_en     = r_wr_en;
  assign bus.mem_wr_strb   = r_wr_strb;
  assign bus.mem_wr_addr   = r_wr_addr;
  assign bus.mem_wr_data   = r_wr_data;
  assign bus.done_valid    = w_done_vld;
  assign bus.done_len      = r_done_len;
  assign bus.done_overflow = r_done_ovf;
  assign bus.done_aborted  = r_done_abt;
endmodule
